// File: rtl/sap_xbus_bridge.sv
// sap_xbus_bridge: CPU-side single-transfer bridge onto an 8-bit phased pin bus.
// Sends address bytes, then write bytes or (after optional turnaround) samples read bytes.
// Optional build macro: SAP_XBUS_TIMEOUT_EN adds an 8-bit stall timeout that aborts to DONE with cpu_err.
module sap_xbus_bridge #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [7:0]        pad_out,
  output logic [7:0]        pad_oe,
  input  logic [7:0]        pad_in,
  output logic [1:0]        pad_phase,
  output logic              pad_strb,
  input  logic              pad_rdy
);

  localparam int unsigned ABYTES = ADDR_W / 8;
  localparam int unsigned DBYTES = DATA_W / 8;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned TURN_W = 4;
  localparam int unsigned TO_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_TURN,
    S_RDATA,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rbuf_q, rbuf_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [7:0]          pad_out_q, pad_out_d;
  logic [7:0]          pad_oe_q, pad_oe_d;
  logic [1:0]          pad_phase_q, pad_phase_d;
  logic                pad_strb_q, pad_strb_d;
  logic                stall;

  // State register and registered outputs, synchronous reset.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      turn_q      <= '0;
      to_q        <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pad_out_q   <= '0;
      pad_oe_q    <= '0;
      pad_phase_q <= 2'b00;
      pad_strb_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      turn_q      <= turn_d;
      to_q        <= to_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pad_out_q   <= pad_out_d;
      pad_oe_q    <= pad_oe_d;
      pad_phase_q <= pad_phase_d;
      pad_strb_q  <= pad_strb_d;
    end
  end

  // Next-state: byte sequencing, turnaround count, read capture and stall timeout.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    turn_d  = turn_q;
    to_d    = to_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          idx_d   = '0;
          turn_d  = '0;
          to_d    = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (pad_rdy) begin
          to_d = '0;
          if (idx_q == IDX_W'(ABYTES - 1)) begin
            idx_d  = '0;
            turn_d = '0;
            if (we_q) begin
              state_d = S_WDATA;
            end else if (WAIT_CYC == 0) begin
              state_d = S_RDATA;
            end else begin
              state_d = S_TURN;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          stall = 1'b1;
        end
      end
      S_WDATA: begin
        if (pad_rdy) begin
          to_d = '0;
          if (idx_q == IDX_W'(DBYTES - 1)) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          stall = 1'b1;
        end
      end
      S_TURN: begin
        if (turn_q == TURN_W'(WAIT_CYC - 1)) begin
          turn_d  = '0;
          state_d = S_RDATA;
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end
      S_RDATA: begin
        if (pad_rdy) begin
          to_d = '0;
          rbuf_d[{idx_q, 3'b000} +: 8] = pad_in;
          if (idx_q == IDX_W'(DBYTES - 1)) begin
            idx_d   = '0;
            rdata_d = rbuf_d;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          stall = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef SAP_XBUS_TIMEOUT_EN
    if (stall) begin
      to_d = to_q + TO_W'(1);
      if (to_q == TO_W'(254)) begin
        to_d    = '0;
        idx_d   = '0;
        err_d   = 1'b1;
        state_d = S_DONE;
      end
    end
`endif
  end

`ifndef SAP_XBUS_TIMEOUT_EN
  logic unused_stall;
  assign unused_stall = stall;
`endif

  // Output decode from the upcoming state so pin outputs leave flops.
  always_comb begin
    pad_out_d   = '0;
    pad_oe_d    = '0;
    pad_phase_d = 2'b00;
    pad_strb_d  = 1'b0;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    unique case (state_d)
      S_ADDR: begin
        pad_out_d   = 8'(addr_d >> {idx_d, 3'b000});
        pad_oe_d    = 8'hFF;
        pad_phase_d = 2'b01;
        pad_strb_d  = 1'b1;
      end
      S_WDATA: begin
        pad_out_d   = 8'(wdata_d >> {idx_d, 3'b000});
        pad_oe_d    = 8'hFF;
        pad_phase_d = 2'b10;
        pad_strb_d  = 1'b1;
      end
      S_TURN: begin
        pad_phase_d = 2'b11;
      end
      S_RDATA: begin
        pad_phase_d = 2'b11;
        pad_strb_d  = 1'b1;
      end
      default: begin
        pad_phase_d = 2'b00;
      end
    endcase
  end

  assign cpu_rdata = rdata_q;
  assign cpu_busy  = busy_q;
  assign cpu_done  = done_q;
  assign cpu_err   = err_q;
  assign pad_out   = pad_out_q;
  assign pad_oe    = pad_oe_q;
  assign pad_phase = pad_phase_q;
  assign pad_strb  = pad_strb_q;

endmodule

// File: tb/tb_sap_xbus_bridge.sv
// Bench for sap_xbus_bridge: two instances (WAIT_CYC 0 and 3) share stimulus; a beat-list
// transaction model predicts every output each cycle, plus literal directed expectations.
module tb_sap_xbus_bridge;

  logic        CLK;
  logic        rst, req, we, rdy;
  logic [15:0] addr, wdata;
  logic [7:0]  pad_in;

  logic [15:0] rdata_w [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic        err_w   [2];
  logic [7:0]  pout_w  [2];
  logic [7:0]  poe_w   [2];
  logic [1:0]  pph_w   [2];
  logic        pstb_w  [2];

  int passed = 0;
  int total  = 0;

  sap_xbus_bridge #(.ADDR_W(16), .DATA_W(16), .WAIT_CYC(0)) u0 (
    .CLK(CLK), .rst(rst), .cpu_req(req), .cpu_we(we), .cpu_addr(addr), .cpu_wdata(wdata),
    .cpu_rdata(rdata_w[0]), .cpu_busy(busy_w[0]), .cpu_done(done_w[0]), .cpu_err(err_w[0]),
    .pad_out(pout_w[0]), .pad_oe(poe_w[0]), .pad_in(pad_in), .pad_phase(pph_w[0]),
    .pad_strb(pstb_w[0]), .pad_rdy(rdy)
  );

  sap_xbus_bridge #(.ADDR_W(16), .DATA_W(16), .WAIT_CYC(3)) u3 (
    .CLK(CLK), .rst(rst), .cpu_req(req), .cpu_we(we), .cpu_addr(addr), .cpu_wdata(wdata),
    .cpu_rdata(rdata_w[1]), .cpu_busy(busy_w[1]), .cpu_done(done_w[1]), .cpu_err(err_w[1]),
    .pad_out(pout_w[1]), .pad_oe(poe_w[1]), .pad_in(pad_in), .pad_phase(pph_w[1]),
    .pad_strb(pstb_w[1]), .pad_rdy(rdy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Transaction model: each accepted request becomes a list of pin beats.
  int          waitc  [2] = '{0, 3};
  int          mstate [2];            // 0 idle, 1 beats in flight, 2 done
  int          pos    [2];
  int          len    [2];
  int          scnt   [2];
  bit          mwe    [2];
  bit          merr   [2];
  logic [15:0] mrbuf  [2];
  logic [15:0] mrdata [2];
  logic [1:0]  bphase [2][32];
  logic [7:0]  bdata  [2][32];
  bit          bneed  [2][32];
  int          bk     [2][32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, required %0h", name, act, exp);
    else passed++;
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic build(input int i);
    int n = 0;
    for (int b = 0; b < 2; b++) begin
      bphase[i][n] = 2'b01; bdata[i][n] = 8'(addr >> (8 * b)); bneed[i][n] = 1; bk[i][n] = -1; n++;
    end
    if (we) begin
      for (int b = 0; b < 2; b++) begin
        bphase[i][n] = 2'b10; bdata[i][n] = 8'(wdata >> (8 * b)); bneed[i][n] = 1; bk[i][n] = -1; n++;
      end
    end else begin
      for (int t = 0; t < waitc[i]; t++) begin
        bphase[i][n] = 2'b11; bdata[i][n] = 8'h00; bneed[i][n] = 0; bk[i][n] = -1; n++;
      end
      for (int b = 0; b < 2; b++) begin
        bphase[i][n] = 2'b11; bdata[i][n] = 8'h00; bneed[i][n] = 1; bk[i][n] = b; n++;
      end
    end
    len[i] = n;
  endtask

  task automatic model_edge();
    logic [15:0] t;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mstate[i] = 0; mrdata[i] = '0; scnt[i] = 0; merr[i] = 0;
      end else if (mstate[i] == 0) begin
        if (req) begin
          build(i); mstate[i] = 1; pos[i] = 0; scnt[i] = 0; merr[i] = 0; mwe[i] = we;
        end
      end else if (mstate[i] == 1) begin
        if (bneed[i][pos[i]] && !rdy) begin
`ifdef SAP_XBUS_TIMEOUT_EN
          scnt[i]++;
          if (scnt[i] == 255) begin mstate[i] = 2; merr[i] = 1; end
`endif
        end else begin
          scnt[i] = 0;
          if (bk[i][pos[i]] >= 0) begin
            t = mrbuf[i];
            t[8 * bk[i][pos[i]] +: 8] = pad_in;
            mrbuf[i] = t;
          end
          pos[i]++;
          if (pos[i] == len[i]) begin
            mstate[i] = 2;
            if (!mwe[i]) mrdata[i] = mrbuf[i];
          end
        end
      end else begin
        mstate[i] = 0;
      end
    end
  endtask

  task automatic compare();
    logic [1:0] ph;
    logic [7:0] eo, ed;
    logic       es;
    for (int i = 0; i < 2; i++) begin
      ph = 2'b00; eo = 8'h00; ed = 8'h00; es = 1'b0;
      if (mstate[i] == 1) begin
        ph = bphase[i][pos[i]];
        ed = bdata[i][pos[i]];
        eo = (ph == 2'b11) ? 8'h00 : 8'hFF;
        es = (ph == 2'b11) ? bneed[i][pos[i]] : 1'b1;
      end
      chk($sformatf("busy%0d", i),  32'(busy_w[i]), 32'(mstate[i] != 0));
      chk($sformatf("done%0d", i),  32'(done_w[i]), 32'(mstate[i] == 2));
      chk($sformatf("err%0d", i),   32'(err_w[i]),  32'(mstate[i] == 2 && merr[i]));
      chk($sformatf("phase%0d", i), 32'(pph_w[i]),  32'(ph));
      chk($sformatf("oe%0d", i),    32'(poe_w[i]),  32'(eo));
      chk($sformatf("strb%0d", i),  32'(pstb_w[i]), 32'(es));
      chk($sformatf("rdata%0d", i), 32'(rdata_w[i]), 32'(mrdata[i]));
      if (ph != 2'b11) chk($sformatf("pout%0d", i), 32'(pout_w[i]), 32'(ed));
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare();
  endtask

  task automatic wait_idle();
    int n = 0;
    req = 0; rdy = 1; rst = 0;
    while ((busy_w[0] || busy_w[1]) && n < 400) begin step(); n++; end
    if (n >= 400) fail_now("wait_idle");
  endtask

  logic [7:0] wr_exp [4] = '{8'h34, 8'h12, 8'hEF, 8'hBE};
  logic [1:0] ph_exp [4] = '{2'b01, 2'b01, 2'b10, 2'b10};

  initial begin
    int d0, d3;
    bit seen;
    for (int i = 0; i < 2; i++) begin
      mstate[i] = 0; mrdata[i] = '0; mrbuf[i] = '0; scnt[i] = 0; merr[i] = 0; pos[i] = 0; len[i] = 0;
    end
    rst = 1; req = 0; we = 0; addr = '0; wdata = '0; rdy = 1; pad_in = '0;
    @(negedge CLK);
    step(); step();
    rst = 0;
    chk("rst_busy", 32'(busy_w[0]), 0);
    chk("rst_rdata", 32'(rdata_w[0]), 0);
    chk("rst_phase", 32'(pph_w[1]), 0);

    // Write 1234/BEEF, ready always high.
    req = 1; we = 1; addr = 16'h1234; wdata = 16'hBEEF;
    step(); req = 0;
    d0 = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) begin
        chk("wr_byte", 32'(pout_w[0]), 32'(wr_exp[c-1]));
        chk("wr_phase", 32'(pph_w[0]), 32'(ph_exp[c-1]));
      end
      if (done_w[0] && d0 == 0) d0 = c;
      step();
    end
    chk("wr_done_cycle", d0, 5);
    wait_idle();

    // Read 0010: u0 sees 5A then C3; u3 exercises three turnaround cycles.
    req = 1; we = 0; addr = 16'h0010;
    step(); req = 0;
    d0 = 0; d3 = 0;
    for (int c = 1; c <= 9; c++) begin
      if (c >= 3 && c <= 5) chk("turn_strb", 32'(pstb_w[1]), 0);
      if (c == 3 || c == 4) chk("rd_oe", 32'(poe_w[0]), 0);
      if (done_w[0] && d0 == 0) begin d0 = c; chk("rd_data", 32'(rdata_w[0]), 32'h0000C35A); end
      if (done_w[1] && d3 == 0) d3 = c;
      pad_in = (c == 3) ? 8'h5A : (c == 4) ? 8'hC3 : 8'h00;
      step();
    end
    chk("rd_done_cycle", d0, 5);
    chk("rd_wait3_done_cycle", d3, 8);
    wait_idle();

    // Ready low four cycles on the second address byte.
    req = 1; we = 1; addr = 16'hA55A; wdata = 16'h0F0F;
    step(); req = 0;
    d0 = 0; d3 = 0;
    for (int c = 1; c <= 11; c++) begin
      if (c >= 2 && c <= 5) chk("stall_hold", 32'(pout_w[0]), 32'h000000A5);
      if (done_w[0] && d0 == 0) d0 = c;
      if (done_w[1] && d3 == 0) d3 = c;
      rdy = !(c >= 2 && c <= 5);
      step();
    end
    chk("stall_done_cycle", d0, 9);
    chk("stall_done_cycle3", d3, 9);
    wait_idle();

    // Reset during write data, then a fresh write.
    req = 1; we = 1; addr = 16'h1111; wdata = 16'h2222;
    step(); req = 0;
    step(); step();
    rst = 1; step(); rst = 0;
    chk("rstmid_busy", 32'(busy_w[0]), 0);
    chk("rstmid_oe", 32'(poe_w[0]), 0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin seen = seen | done_w[0]; step(); end
    chk("rstmid_nodone", 32'(seen), 0);
    req = 1; we = 1; addr = 16'h3344; wdata = 16'h5566;
    step(); req = 0;
    d0 = 0;
    for (int c = 1; c <= 6; c++) begin
      if (done_w[0] && d0 == 0) d0 = c;
      step();
    end
    chk("rstmid_new_done", d0, 5);
    wait_idle();

    // Ready stuck low.
    req = 1; we = 1; addr = 16'h7777; wdata = 16'h8888;
    step(); req = 0; rdy = 0;
    d0 = 0; seen = 0;
    for (int c = 1; c <= 300; c++) begin
      if (done_w[0] && d0 == 0) begin d0 = c; seen = err_w[0]; end
      if (c == 300) begin
`ifdef SAP_XBUS_TIMEOUT_EN
        chk("timeout_cycle", d0, 256);
        chk("timeout_err", 32'(seen), 1);
`else
        chk("stuck_busy", 32'(busy_w[0]), 1);
        chk("stuck_nodone", d0, 0);
`endif
      end
      step();
    end
    wait_idle();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      rst    = ($urandom_range(0, 199) == 0);
      req    = $urandom_range(0, 1) == 1;
      we     = $urandom_range(0, 1) == 1;
      addr   = 16'($urandom);
      wdata  = 16'($urandom);
      pad_in = 8'($urandom);
      rdy    = ($urandom_range(0, 3) != 0);
      step();
    end
    wait_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
